// File: rtl/maxnet_controller.sv
// Sequencer for the four-neuron floating-point max network: loads inputs,
// repeats inhibition passes until a single winner, a tie or the pass limit.
module maxnet_controller #(
  parameter int unsigned DP_LAT   = 3,
  parameter int unsigned MAX_ITER = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] alive,
  output logic       ld_init,
  output logic       dp_en,
  output logic       ld_iter,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic [7:0] iter_cnt,
  output logic       tie,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_ITER, S_UPDATE, S_DONE
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(DP_LAT - 1);
  localparam logic [7:0] MAX_CNT   = 8'(MAX_ITER);

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] prev_q, prev_d;
  logic [7:0] iter_q, iter_d;
  logic [1:0] winner_q, winner_d;
  logic       tie_q, tie_d;
  logic       timeout_q, timeout_d;
  logic [2:0] alive_cnt;

  // Last assignment wins, so the lowest set bit ends up selected.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    low_idx = 2'd0;
    if (v[3]) low_idx = 2'd3;
    if (v[2]) low_idx = 2'd2;
    if (v[1]) low_idx = 2'd1;
    if (v[0]) low_idx = 2'd0;
  endfunction

  assign alive_cnt = 3'(alive[0]) + 3'(alive[1]) + 3'(alive[2]) + 3'(alive[3]);

  always_comb begin
    state_d   = state_q;
    start_d   = start;
    wait_d    = wait_q;
    prev_d    = prev_q;
    iter_d    = iter_q;
    winner_d  = winner_q;
    tie_d     = tie_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start && !start_q) begin
          state_d   = S_LOAD;
          iter_d    = 8'd0;
          winner_d  = 2'd0;
          tie_d     = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_LOAD: begin
        prev_d  = 4'hF;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (alive_cnt == 3'd1) begin
          winner_d = low_idx(alive);
          state_d  = S_DONE;
        end else if (alive_cnt == 3'd0) begin
          // Everyone died this pass: fall back to the survivors of the last one.
          tie_d    = 1'b1;
          winner_d = low_idx(prev_q);
          state_d  = S_DONE;
        end else if (iter_q == MAX_CNT) begin
          timeout_d = 1'b1;
          winner_d  = low_idx(alive);
          state_d   = S_DONE;
        end else begin
          prev_d  = alive;
          wait_d  = WAIT_INIT;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (wait_q == 4'd0) state_d = S_UPDATE;
        else                wait_d  = wait_q - 4'd1;
      end
      S_UPDATE: begin
        iter_d  = iter_q + 8'd1;
        state_d = S_CHECK;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      wait_q    <= 4'd0;
      prev_q    <= 4'd0;
      iter_q    <= 8'd0;
      winner_q  <= 2'd0;
      tie_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      wait_q    <= wait_d;
      prev_q    <= prev_d;
      iter_q    <= iter_d;
      winner_q  <= winner_d;
      tie_q     <= tie_d;
      timeout_q <= timeout_d;
    end
  end

  assign ld_init  = (state_q == S_LOAD);
  assign dp_en    = (state_q == S_ITER);
  assign ld_iter  = (state_q == S_UPDATE);
  assign busy     = (state_q == S_LOAD) || (state_q == S_CHECK) ||
                    (state_q == S_ITER) || (state_q == S_UPDATE);
  assign done     = (state_q == S_DONE);
  assign winner   = winner_q;
  assign iter_cnt = iter_q;
  assign tie      = tie_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Random and directed runs of maxnet_controller against a run-level model:
// the model derives outcome and cycle timeline from the alive sequence alone.
module tb_maxnet_controller;
  localparam int L  = 3;
  localparam int MI = 4;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] alive;
  logic       ld_init, dp_en, ld_iter, busy, done, tie, timeout;
  logic [1:0] winner;
  logic [7:0] iter_cnt;

  int n_cmp = 0, n_err = 0;
  logic [3:0] scr [0:15];
  int scr_len;
  int r_d, r_n, r_init, r_dp, r_it, r_done_k;
  logic [1:0] r_w;
  logic r_t, r_to;

  maxnet_controller #(.DP_LAT(L), .MAX_ITER(MI)) dut (
    .clk(clk), .rst(rst), .start(start), .alive(alive),
    .ld_init(ld_init), .dp_en(dp_en), .ld_iter(ld_iter), .busy(busy),
    .done(done), .winner(winner), .iter_cnt(iter_cnt), .tie(tie),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int low(input logic [3:0] v);
    for (int j = 0; j < 4; j++) if (v[j]) return j;
    return 0;
  endfunction

  function automatic logic [3:0] scr_at(input int i);
    return scr[(i < scr_len) ? i : scr_len - 1];
  endfunction

  // Outcome of a run given the alive value seen at each successive check.
  function automatic void model(output int n, output logic [1:0] w,
                                output logic t, output logic to);
    logic [3:0] prev = 4'hF;
    logic [3:0] a;
    n = 0; w = 0; t = 0; to = 0;
    for (int i = 0; i <= MI; i++) begin
      a = scr_at(i);
      n = i;
      if ($countones(a) == 1) begin w = 2'(low(a)); return; end
      if ($countones(a) == 0) begin t = 1; w = 2'(low(prev)); return; end
      if (i == MI) begin to = 1; w = 2'(low(a)); return; end
      prev = a;
    end
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, "_outs"}, {ld_init, dp_en, ld_iter, busy, done, tie, timeout}, 0);
    chk({nm, "_data"}, {winner, iter_cnt}, 0);
  endtask

  // Called at a negedge. trig raises start so the next posedge is cycle 0.
  task automatic run_case(input bit trig, input int rst_at, input bit glitch,
                          input bit rel_start);
    int p = 0, r, in_win;
    bit e_init, e_dp, e_it;
    model(r_n, r_w, r_t, r_to);
    r_d = 3 + r_n * (L + 2);
    r_init = 0; r_dp = 0; r_it = 0; r_done_k = 0;
    if (trig) start = 1'b1;
    for (int k = 1; k <= r_d + 1; k++) begin
      @(negedge clk);
      in_win = (k >= 3 && k < r_d) ? 1 : 0;
      r = (k - 3) % (L + 2);
      e_init = (k == 1);
      e_dp   = in_win != 0 && r < L;
      e_it   = in_win != 0 && r == L;
      chk("ld_init", ld_init, e_init);
      chk("dp_en", dp_en, e_dp);
      chk("ld_iter", ld_iter, e_it);
      chk("busy", busy, k < r_d);
      chk("done", done, k == r_d);
      r_init += int'(ld_init); r_dp += int'(dp_en); r_it += int'(ld_iter);
      if (done === 1'b1 && r_done_k == 0) r_done_k = k;
      if (k >= r_d) begin
        chk("winner", winner, r_w);
        chk("iter_cnt", iter_cnt, r_n);
        chk("tie", tie, r_t);
        chk("timeout", timeout, r_to);
      end
      if (ld_init === 1'b1 || ld_iter === 1'b1) begin alive = scr_at(p); p++; end
      if (glitch && k == 4) start = 1'b0;
      if (glitch && k == 5) start = 1'b1;
      if (rel_start && k == 2) start = 1'b0;
      if (k == rst_at) begin
        rst = 1'b0;
        #1 chk_zero("rst_async");
        return;
      end
    end
  endtask

  task automatic idle_check(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_ld_init", ld_init, 0);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; alive = 4'h0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Normal run
    scr_len = 3; scr[0] = 4'b1111; scr[1] = 4'b0110; scr[2] = 4'b0010;
    run_case(1, 0, 0, 1);
    chk("norm_model_n", r_n, 2);
    chk("norm_model_w", r_w, 1);
    chk("norm_done_cyc", r_done_k, 13);
    chk("norm_ld_iter_cnt", r_it, 2);
    chk("norm_dp_en_cnt", r_dp, 6);
    chk("norm_ld_init_cnt", r_init, 1);

    // Immediate win
    @(negedge clk);
    scr_len = 1; scr[0] = 4'b1000;
    run_case(1, 0, 0, 1);
    chk("win_done_cyc", r_done_k, 3);
    chk("win_model_w", r_w, 3);
    chk("win_dp_en_cnt", r_dp, 0);

    // Tie
    @(negedge clk);
    scr_len = 3; scr[0] = 4'b1111; scr[1] = 4'b0101; scr[2] = 4'b0000;
    run_case(1, 0, 0, 1);
    chk("tie_done_cyc", r_done_k, 13);
    chk("tie_model_t", r_t, 1);
    chk("tie_model_w", r_w, 0);

    // Tie right after load
    @(negedge clk);
    scr_len = 1; scr[0] = 4'b0000;
    run_case(1, 0, 0, 1);
    chk("tie0_done_cyc", r_done_k, 3);

    // Timeout
    @(negedge clk);
    scr_len = 1; scr[0] = 4'b0011;
    run_case(1, 0, 0, 1);
    chk("to_done_cyc", r_done_k, 23);
    chk("to_model_to", r_to, 1);
    chk("to_model_n", r_n, 4);

    // Reset mid-run with start held, then retrigger on release
    @(negedge clk);
    scr_len = 2; scr[0] = 4'b1111; scr[1] = 4'b0100;
    run_case(1, 6, 0, 0);
    repeat (2) begin @(negedge clk); chk_zero("rst_hold"); end
    rst = 1'b1;
    run_case(0, 0, 0, 0);
    chk("retrig_done_cyc", r_done_k, 8);

    // Start still held: no new run; then a mid-run start pulse does nothing
    idle_check(6);
    start = 1'b0;
    @(negedge clk);
    scr_len = 2; scr[0] = 4'b0111; scr[1] = 4'b0001;
    run_case(1, 0, 1, 0);
    idle_check(6);
    start = 1'b0;
    @(negedge clk);

    // Random runs
    for (int t = 0; t < 40; t++) begin
      scr_len = $urandom_range(1, 6);
      for (int i = 0; i < scr_len; i++) scr[i] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) scr[0] = 4'hF;
      run_case(1, 0, $urandom_range(0, 3) == 0, 1);
      start = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/maxnet_controller.md
# maxnet_controller

Sequencing controller for the four-input floating-point max-finding network (`neuralNetwork`). It replaces the network's internal start/Done handling. It detects a start request, loads the four IEEE-754 inputs into the datapath, and runs mutual-inhibition iterations, waiting a fixed datapath latency each time. It stops when exactly one neuron remains active, none remain, or an iteration limit is hit, then reports the winner index and termination status.

## Interface
Parameters:
- DP_LAT, 3: cycles the inhibition datapath (float mult/add chain) needs from `dp_en` rise to valid results; legal 1..15.
- MAX_ITER, 32: maximum inhibition iterations before forced termination; legal 1..255.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 forces reset state immediately.
- start  in  1  run request; a run is triggered by a 0→1 edge as sampled on clk.
- alive  in  4  per-neuron activation > 0 flags from datapath registers (bit i = neuron i).
- ld_init  out  1  load x1..x4 into activation registers.
- dp_en  out  1  enable inhibition datapath computation.
- ld_iter  out  1  latch updated activations into activation registers.
- busy  out  1  run in progress (LOAD through CHECK).
- done  out  1  one-cycle completion pulse.
- winner  out  2  index of winning neuron.
- iter_cnt  out  8  completed iterations of current/last run.
- tie  out  1  run ended with all neurons inactive.
- timeout  out  1  run ended by MAX_ITER.

## Operation
- States: IDLE, LOAD, CHECK, ITER, UPDATE, DONE.
- Start edge detect: register `start_q`, cleared by reset. Trigger = start & ~start_q, evaluated in IDLE only. Edges in any other state are ignored. start falling mid-run is ignored.
- Because `start_q` resets to 0, start held high across a reset release triggers a new run.
- IDLE: on trigger go to LOAD. Clear iter_cnt, tie, timeout and winner at this transition.
- LOAD (1 cycle): ld_init=1. Go to CHECK.
- CHECK (1 cycle): count = popcount(alive).
  - count==1: winner=index of set bit; go to DONE.
  - count==0: tie=1; winner=lowest set index of `prev_alive`; go to DONE.
  - count>1 and iter_cnt==MAX_ITER: timeout=1; winner=lowest set index of alive; go to DONE.
  - Otherwise: `prev_alive`←alive; go to ITER.
- ITER (DP_LAT cycles): dp_en=1; a wait counter runs from DP_LAT-1 down to 0. Go to UPDATE.
- UPDATE (1 cycle): ld_iter=1; iter_cnt+1 (never wraps within the legal range). Go to CHECK.
- DONE (1 cycle): done=1. Go to IDLE.
- `prev_alive` resets to 4'b0000 and is set to 4'b1111 in LOAD. A tie straight after load therefore reports winner=0.
- winner, iter_cnt, tie and timeout hold their values from DONE until the next trigger.
- At most one of ld_init, dp_en and ld_iter is high in any cycle. All control outputs are decoded from state (Moore).

## Timing
- Reset values: state IDLE, all outputs 0, start_q 0, wait counter 0, prev_alive 0.
- Reset mid-run: immediate return to IDLE. No done pulse. Outputs are cleared asynchronously.
- Let cycle 0 be the clock edge where the trigger is sampled. Then:
  - LOAD is cycle 1 and the first CHECK is cycle 2.
  - Each iteration adds DP_LAT+2 cycles.
  - done is high in cycle 3 + n·(DP_LAT+2), where n = iterations performed.
- busy is high from LOAD through the final CHECK. It is low in DONE and IDLE.
- alive is sampled only in CHECK, and must reflect the registers written by the preceding LOAD/UPDATE edge.
- The earliest retrigger is 2 cycles after done: start must be seen low, then high.

## Test plan
- Normal run, DP_LAT=3: trigger, with alive=1111 at the first CHECK, 0110 at the second and 0010 at the third. Required: done in cycle 13, winner=1, iter_cnt=2, tie=0, timeout=0; exactly 2 ld_iter pulses, 6 dp_en cycles and 1 ld_init pulse.
- Immediate win: alive=1000 at the first CHECK. Required: done in cycle 3, winner=3, iter_cnt=0, no dp_en.
- Tie: 1111 at the first CHECK, then 0101, then 0000. Required: tie=1, winner=0, iter_cnt=2, done in cycle 13.
- Timeout, MAX_ITER=4: alive held at 0011. Required: timeout=1, winner=0, iter_cnt=4, done in cycle 23.
- Reset and retrigger: assert rst low in cycle 6 of a run while start stays high. Required: outputs 0 immediately and no done pulse. After rst release, start still high gives a new trigger and LOAD on the next cycle.
- Held start: keep start high through done. Required: no second run until start goes 0 then 1. A start pulse during busy produces no effect.
